// File: rtl/vector_response_checker_if.sv
// Sample/verdict bundle between a stimulus source and vector_response_checker.
// The source drives the master side and the checker implements the slave side.
interface vector_response_checker_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic                    start;
  logic                    sample_valid;
  logic [WIDTH-1:0]        vec_in;
  logic                    dut_out;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic                    timeout;
  logic [CNT_W-1:0]        err_count;
  logic [(1<<WIDTH)-1:0]   coverage;
  logic                    first_err_valid;
  logic [WIDTH-1:0]        first_err_vec;

  modport master (
    output start, sample_valid, vec_in, dut_out,
    input  busy, done, pass, timeout, err_count, coverage,
           first_err_valid, first_err_vec
  );

  modport slave (
    input  start, sample_valid, vec_in, dut_out,
    output busy, done, pass, timeout, err_count, coverage,
           first_err_valid, first_err_vec
  );
endinterface

// File: rtl/vector_response_checker.sv
// Checks a combinational unit's 1-bit response against EXP_TABLE, tracks vector coverage and stalls.
// Define VRC_FIRST_ERR_CAPTURE_EN to latch the vector of the first mismatch in each run.
module vector_response_checker #(
  parameter int                    WIDTH     = 3,
  parameter logic [(1<<WIDTH)-1:0] EXP_TABLE = 8'b1110_1000,
  parameter int                    CNT_W     = 8,
  parameter int                    TIMEOUT   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  vector_response_checker_if.slave bus
);

  localparam int NV   = 1 << WIDTH;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_errCount;
  logic [CNT_W-1:0]  w_errNext;
  logic [NV-1:0]     r_cov;
  logic [NV-1:0]     w_covNext;
  logic [WD_W-1:0]   r_wdCnt;
  logic [WD_W-1:0]   w_wdNext;
  logic              r_pass;
  logic              r_timeout;
  logic              w_start;
  logic              w_sample;
  logic              w_mismatch;
  logic              w_covFull;
  logic              w_wdExpire;

  // A start from DONE is treated exactly like one from IDLE; start during RUN is ignored.
  always_comb begin
    w_nextState = r_state;
    w_start     = bus.start && (r_state != RUN);
    w_sample    = bus.sample_valid && (r_state == RUN);
    w_mismatch  = w_sample && (bus.dut_out != EXP_TABLE[bus.vec_in]);
    w_errNext   = r_errCount;
    if (w_mismatch && (r_errCount != '1)) begin
      w_errNext = r_errCount + 1'b1;
    end
    w_covNext = r_cov;
    if (w_sample) begin
      w_covNext[bus.vec_in] = 1'b1;
    end
    w_covFull  = w_sample && (&w_covNext);
    w_wdNext   = r_wdCnt + 1'b1;
    w_wdExpire = (r_state == RUN) && !bus.sample_valid && (w_wdNext == WD_W'(TIMEOUT));

    case (r_state)
      IDLE, DONE: if (w_start) w_nextState = RUN;
      RUN:        if (w_covFull || w_wdExpire) w_nextState = DONE;
      default:    w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // The watchdog only advances on sample-free RUN cycles, so a final sample always beats it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errCount <= '0;
      r_cov      <= '0;
      r_wdCnt    <= '0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_start) begin
      r_errCount <= '0;
      r_cov      <= '0;
      r_wdCnt    <= '0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (r_state == RUN) begin
      if (bus.sample_valid) begin
        r_errCount <= w_errNext;
        r_cov      <= w_covNext;
        r_wdCnt    <= '0;
        if (w_covFull) r_pass <= (w_errNext == '0);
      end else begin
        r_wdCnt <= w_wdNext;
        if (w_wdExpire) begin
          r_timeout <= 1'b1;
          r_pass    <= 1'b0;
        end
      end
    end
  end

`ifdef VRC_FIRST_ERR_CAPTURE_EN
  logic             r_feValid;
  logic [WIDTH-1:0] r_feVec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feValid <= 1'b0;
      r_feVec   <= '0;
    end else if (w_start) begin
      r_feValid <= 1'b0;
      r_feVec   <= '0;
    end else if (w_mismatch && !r_feValid) begin
      r_feValid <= 1'b1;
      r_feVec   <= bus.vec_in;
    end
  end

  assign bus.first_err_valid = r_feValid;
  assign bus.first_err_vec   = r_feVec;
`else
  assign bus.first_err_valid = 1'b0;
  assign bus.first_err_vec   = '0;
`endif

  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.pass      = r_pass;
  assign bus.timeout   = r_timeout;
  assign bus.err_count = r_errCount;
  assign bus.coverage  = r_cov;

endmodule

// File: tb/tb_vector_response_checker.sv
// Self-checking bench: two checkers (8-bit and 2-bit error counters) share one stimulus stream
// and are compared every cycle against a run-level behavioural model.
module tb_vector_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_response_checker_if #(.WIDTH(3), .CNT_W(8)) ifA ();
  vector_response_checker_if #(.WIDTH(3), .CNT_W(2)) ifB ();

  assign ifB.start        = ifA.start;
  assign ifB.sample_valid = ifA.sample_valid;
  assign ifB.vec_in       = ifA.vec_in;
  assign ifB.dut_out      = ifA.dut_out;

  vector_response_checker #(.WIDTH(3), .EXP_TABLE(8'b1110_1000), .CNT_W(8), .TIMEOUT(16)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA.slave));
  vector_response_checker #(.WIDTH(3), .EXP_TABLE(8'b1110_1000), .CNT_W(2), .TIMEOUT(16)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB.slave));

  logic [7:0] expTab = 8'b1110_1000;

  int totalChecks = 0;
  int badChecks   = 0;

  // Run-level reference state: what a correct checker has seen so far in this run.
  bit         mRunning, mDone, mTimeout, mPass, mFeValid;
  int         mErrs, mIdle;
  logic [7:0] mCov;
  logic [2:0] mFeVec;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int satCnt(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic modelClear();
    mErrs = 0; mIdle = 0; mCov = '0; mTimeout = 0; mPass = 0; mFeValid = 0; mFeVec = '0;
  endtask

  task automatic modelEdge(input bit st, input bit sv, input logic [2:0] vec, input bit out);
    if (!mRunning && st) begin
      modelClear();
      mRunning = 1; mDone = 0;
    end else if (mRunning) begin
      if (sv) begin
        if (out != expTab[vec]) begin
          mErrs++;
          if (!mFeValid) begin mFeValid = 1; mFeVec = vec; end
        end
        mCov[vec] = 1'b1;
        mIdle = 0;
        if (mCov == 8'hFF) begin mRunning = 0; mDone = 1; mPass = (mErrs == 0); end
      end else begin
        mIdle++;
        if (mIdle == 16) begin mRunning = 0; mDone = 1; mTimeout = 1; mPass = 0; end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".busy"},    32'(ifA.busy),      32'(mRunning));
    checkOutput({tag, ".done"},    32'(ifA.done),      32'(mDone));
    checkOutput({tag, ".pass"},    32'(ifA.pass),      32'(mPass));
    checkOutput({tag, ".timeout"}, 32'(ifA.timeout),   32'(mTimeout));
    checkOutput({tag, ".errA"},    32'(ifA.err_count), 32'(satCnt(mErrs, 255)));
    checkOutput({tag, ".errB"},    32'(ifB.err_count), 32'(satCnt(mErrs, 3)));
    checkOutput({tag, ".passB"},   32'(ifB.pass),      32'(mPass));
    checkOutput({tag, ".cov"},     32'(ifA.coverage),  32'(mCov));
`ifdef VRC_FIRST_ERR_CAPTURE_EN
    checkOutput({tag, ".feValid"}, 32'(ifA.first_err_valid), 32'(mFeValid));
    checkOutput({tag, ".feVec"},   32'(ifA.first_err_vec),   32'(mFeVec));
`else
    checkOutput({tag, ".feValid"}, 32'(ifA.first_err_valid), 32'd0);
    checkOutput({tag, ".feVec"},   32'(ifA.first_err_vec),   32'd0);
`endif
  endtask

  task automatic applyStimulus(input string tag, input bit st, input bit sv, input logic [2:0] vec, input bit out);
    ifA.start = st; ifA.sample_valid = sv; ifA.vec_in = vec; ifA.dut_out = out;
    @(posedge clk);
    modelEdge(st, sv, vec, out);
    #1;
    checkAll(tag);
  endtask

  task automatic sweep(input string tag, input int badVec);
    for (int v = 0; v < 8; v++) begin
      applyStimulus(tag, 0, 1, 3'(v), expTab[v] ^ (v == badVec));
      if (v == badVec) applyStimulus(tag, 0, 1, 3'(v), ~expTab[v]);
    end
  endtask

  initial begin
    ifA.start = 0; ifA.sample_valid = 0; ifA.vec_in = '0; ifA.dut_out = 0;
    mRunning = 0; mDone = 0; modelClear();
    #12;
    checkAll("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean sweep
    applyStimulus("cleanStart", 1, 0, 0, 0);
    sweep("clean", -1);
    checkOutput("clean.donePass", {31'd0, ifA.done & ifA.pass}, 32'd1);
    checkOutput("clean.covFull", 32'(ifA.coverage), 32'hFF);
    for (int i = 0; i < 3; i++) applyStimulus("doneHold", 0, 1, 3'(i), 0);

    // Single fault on vector 5, repeated
    applyStimulus("faultStart", 1, 0, 0, 0);
    sweep("fault", 5);
    checkOutput("fault.err", 32'(ifA.err_count), 32'd2);
    checkOutput("fault.pass", 32'(ifA.pass), 32'd0);
`ifdef VRC_FIRST_ERR_CAPTURE_EN
    checkOutput("fault.feVec", 32'(ifA.first_err_vec), 32'd5);
`endif

    // Stalled source
    applyStimulus("stallStart", 1, 0, 0, 0);
    for (int v = 0; v < 4; v++) applyStimulus("stallVec", 0, 1, 3'(v), expTab[v]);
    for (int i = 0; i < 15; i++) applyStimulus("stallWait", 0, 0, 0, 0);
    checkOutput("stall.notYet", 32'(ifA.done), 32'd0);
    applyStimulus("stallWait", 0, 0, 0, 0);
    checkOutput("stall.timeout", {30'd0, ifA.done, ifA.timeout}, 32'd3);
    checkOutput("stall.cov", 32'(ifA.coverage), 32'h0F);

    // Saturation: 6 mismatches avoiding vector 7, then 7 correct
    applyStimulus("satStart", 1, 0, 0, 0);
    for (int v = 0; v < 6; v++) applyStimulus("satBad", 0, 1, 3'(v), ~expTab[v]);
    applyStimulus("satGood", 0, 1, 6, expTab[6]);
    applyStimulus("satGood", 0, 1, 7, expTab[7]);
    checkOutput("sat.errB", 32'(ifB.err_count), 32'd3);
    checkOutput("sat.passB", 32'(ifB.pass), 32'd0);

    // Watchdog tie with final sample: sample wins
    applyStimulus("tieStart", 1, 0, 0, 0);
    for (int v = 0; v < 7; v++) applyStimulus("tieVec", 0, 1, 3'(v), expTab[v]);
    for (int i = 0; i < 15; i++) applyStimulus("tieWait", 0, 0, 0, 0);
    applyStimulus("tieLast", 0, 1, 7, expTab[7]);
    checkOutput("tie.result", {29'd0, ifA.done, ifA.pass, ifA.timeout}, 32'd6);

    // Protocol edges
    applyStimulus("idleStartSample", 1, 1, 7, expTab[7]);
    checkOutput("proto.covZero", 32'(ifA.coverage), 32'd0);
    applyStimulus("proto", 0, 1, 0, ~expTab[0]);
    applyStimulus("runStart", 1, 1, 1, expTab[1]);
    checkOutput("proto.noClear", 32'(ifA.coverage), 32'h03);
    for (int v = 2; v < 8; v++) applyStimulus("proto", 0, 1, 3'(v), expTab[v]);
    applyStimulus("doneStart", 1, 1, 4, expTab[4]);
    checkOutput("proto.restart", {ifA.busy, 23'd0, ifA.coverage}, 32'h8000_0000);

    // Asynchronous reset mid-run
    for (int v = 0; v < 3; v++) applyStimulus("preReset", 0, 1, 3'(v), ~expTab[v]);
    #2 rst_n = 1'b0;
    mRunning = 0; mDone = 0; modelClear();
    #1 checkAll("asyncReset");
    #3 rst_n = 1'b1;
    applyStimulus("postResetStart", 1, 0, 0, 0);
    sweep("postReset", -1);
    checkOutput("postReset.pass", 32'(ifA.pass), 32'd1);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      int cyc = 0;
      applyStimulus("randStart", 1, 0, 0, 0);
      while (!mDone && cyc < 400) begin
        logic [2:0] v;
        bit sv, bad, st;
        v   = 3'($urandom_range(0, 7));
        sv  = ($urandom_range(0, 3) != 0);
        bad = ($urandom_range(0, 9) == 0);
        st  = ($urandom_range(0, 15) == 0);
        if (r == 7 && cyc > 5) sv = 0;
        applyStimulus("rand", st, sv, v, expTab[v] ^ bad);
        cyc++;
      end
      checkOutput("rand.doneBound", 32'(ifA.done), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
